// File: rtl/cvw.sv
// Shared constants and types for the RVVI trace transmit path.
package cvw;

  localparam int unsigned ETH_MIN_FRAME_BYTES = 60;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    PAD
  } txbufstate_t;

endpackage

// File: rtl/rvvi_sync_fifo.sv
// Dual-port storage with a registered read port; pointers are owned by the instantiating block
// so it can rewind or hold them as needed.
module rvvi_sync_fifo #(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             WrEn,
  input  logic [AW-1:0]    WrAddr,
  input  logic [WIDTH-1:0] WrData,
  input  logic             RdEn,
  input  logic [AW-1:0]    RdAddr,
  output logic [WIDTH-1:0] RdData
);

  logic [WIDTH-1:0] Mem [DEPTH];

  always_ff @(posedge clk) begin
    if (WrEn) Mem[WrAddr] <= WrData;
    if (RdEn) RdData <= Mem[RdAddr];
  end

endmodule

// File: rtl/rvvi_tx_frame_buffer.sv
// Store-and-forward buffer: whole 32-bit frames in, bubble-free zero-padded byte stream out.
// Define RVVI_TXBUF_STATS_EN to add the TxFrameCount/TxByteCount statistics ports.
module rvvi_tx_frame_buffer
  import cvw::*;
#(
  parameter  int unsigned DEPTH_WORDS     = 512,
  parameter  int unsigned MAX_FRAMES      = 8,
  parameter  int unsigned MIN_FRAME_BYTES = ETH_MIN_FRAME_BYTES,
  localparam int unsigned PendW           = $clog2(MAX_FRAMES + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      RvviAxiWdata,
  input  logic [3:0]       RvviAxiWstrb,
  input  logic             RvviAxiWlast,
  input  logic             RvviAxiWvalid,
  output logic             RvviAxiWready,
  output logic [7:0]       TxData,
  output logic             TxValid,
  output logic             TxLast,
  input  logic             TxReady,
  output logic             FrameDropped,
  output logic [PendW-1:0] FramesPending
`ifdef RVVI_TXBUF_STATS_EN
  ,
  output logic [31:0]      TxFrameCount,
  output logic [31:0]      TxByteCount
`endif
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam int unsigned PW    = AW + 1;
  localparam int unsigned QAW   = $clog2(MAX_FRAMES);
  localparam int unsigned LenW  = 11;
  localparam int unsigned ByteW = LenW + 2;

  logic [PW-1:0]    WrPtr, CommitPtr, RdPtr, RdPtrNext;
  logic [QAW-1:0]   LqWrPtr, LqRdPtr;
  logic [LenW-1:0]  WcCnt, LenData;
  logic [ByteW-1:0] ByteCnt, ByteCntNext, FrameBytes, LastDataByte;
  logic [31:0]      RdWord;
  logic             Active, Dropping;
  logic             Full, LenqFull, Accept, Commit, DropStart, Pop, LongFrame;
  txbufstate_t      State, NextState;

  logic unusedStrb;
  assign unusedStrb = ^RvviAxiWstrb;

  // ---------------- write side ----------------
  assign Full      = (WrPtr[PW-1] != RdPtr[PW-1]) && (WrPtr[AW-1:0] == RdPtr[AW-1:0]);
  assign LenqFull  = FramesPending == PendW'(MAX_FRAMES);
  assign RvviAxiWready = Active & (Dropping | (~Full & ~LenqFull));
  assign Accept    = RvviAxiWvalid & RvviAxiWready;
  assign Commit    = Accept & RvviAxiWlast & ~Dropping;
  // Nothing queued can drain to make room, so the in-progress frame can never fit.
  assign DropStart = Full & (FramesPending == '0) & (WcCnt != '0) & ~Dropping;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      Active       <= 1'b0;
      WrPtr        <= '0;
      CommitPtr    <= '0;
      WcCnt        <= '0;
      LqWrPtr      <= '0;
      Dropping     <= 1'b0;
      FrameDropped <= 1'b0;
    end else begin
      Active <= 1'b1;
      if (DropStart) begin
        WrPtr        <= CommitPtr;
        WcCnt        <= '0;
        Dropping     <= 1'b1;
        FrameDropped <= 1'b1;
      end else if (Accept) begin
        if (Dropping) begin
          if (RvviAxiWlast) Dropping <= 1'b0;
        end else begin
          WrPtr <= WrPtr + PW'(1);
          if (RvviAxiWlast) begin
            CommitPtr <= WrPtr + PW'(1);
            WcCnt     <= '0;
            LqWrPtr   <= LqWrPtr + QAW'(1);
          end else begin
            WcCnt <= WcCnt + LenW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) FramesPending <= '0;
    else         FramesPending <= FramesPending + PendW'(Commit) - PendW'(Pop);
  end

  rvvi_sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH_WORDS)
  ) u_data_fifo (
    .clk    (clk),
    .WrEn   (Accept & ~Dropping),
    .WrAddr (WrPtr[AW-1:0]),
    .WrData (RvviAxiWdata),
    .RdEn   (1'b1),
    .RdAddr (RdPtrNext[AW-1:0]),
    .RdData (RdWord)
  );

  rvvi_sync_fifo #(
    .WIDTH (LenW),
    .DEPTH (MAX_FRAMES)
  ) u_len_queue (
    .clk    (clk),
    .WrEn   (Commit),
    .WrAddr (LqWrPtr),
    .WrData (WcCnt + LenW'(1)),
    .RdEn   (Pop),
    .RdAddr (LqRdPtr),
    .RdData (LenData)
  );

  // ---------------- read side ----------------
  assign Pop          = (State == IDLE) && (FramesPending != '0);
  assign FrameBytes   = {LenData, 2'b00};
  assign LastDataByte = FrameBytes - ByteW'(1);
  assign LongFrame    = FrameBytes >= ByteW'(MIN_FRAME_BYTES);

  always_comb begin
    NextState   = State;
    ByteCntNext = ByteCnt;
    RdPtrNext   = RdPtr;
    TxValid     = 1'b0;
    TxLast      = 1'b0;
    TxData      = '0;
    unique case (State)
      IDLE: begin
        if (Pop) begin
          NextState   = SEND;
          ByteCntNext = '0;
        end
      end
      SEND: begin
        TxValid = 1'b1;
        TxData  = RdWord[{ByteCnt[1:0], 3'b000} +: 8];
        TxLast  = (ByteCnt == LastDataByte) && LongFrame;
        if (TxReady) begin
          ByteCntNext = ByteCnt + ByteW'(1);
          if (ByteCnt[1:0] == 2'd3) RdPtrNext = RdPtr + PW'(1);
          if (ByteCnt == LastDataByte) NextState = LongFrame ? IDLE : PAD;
        end
      end
      PAD: begin
        TxValid = 1'b1;
        TxLast  = ByteCnt == ByteW'(MIN_FRAME_BYTES - 1);
        if (TxReady) begin
          ByteCntNext = ByteCnt + ByteW'(1);
          if (TxLast) NextState = IDLE;
        end
      end
      default: NextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      State   <= IDLE;
      ByteCnt <= '0;
      RdPtr   <= '0;
      LqRdPtr <= '0;
    end else begin
      State   <= NextState;
      ByteCnt <= ByteCntNext;
      RdPtr   <= RdPtrNext;
      if (Pop) LqRdPtr <= LqRdPtr + QAW'(1);
    end
  end

`ifdef RVVI_TXBUF_STATS_EN
  logic TxFire;
  assign TxFire = TxValid & TxReady;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      TxFrameCount <= '0;
      TxByteCount  <= '0;
    end else begin
      if (TxFire)          TxByteCount  <= TxByteCount + 32'd1;
      if (TxFire & TxLast) TxFrameCount <= TxFrameCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rvvi_tx_frame_buffer.sv
// Directed bench for rvvi_tx_frame_buffer (32-word buffer so two 16-word frames fit together).
module tb_rvvi_tx_frame_buffer;

  localparam int unsigned DEPTH_WORDS = 32;
  localparam int unsigned MAX_FRAMES  = 8;
  localparam int unsigned PendW       = $clog2(MAX_FRAMES + 1);

  logic             clk = 1'b0;
  logic             resetn = 1'b0;
  logic [31:0]      RvviAxiWdata = '0;
  logic [3:0]       RvviAxiWstrb = 4'hf;
  logic             RvviAxiWlast = 1'b0;
  logic             RvviAxiWvalid = 1'b0;
  logic             RvviAxiWready;
  logic [7:0]       TxData;
  logic             TxValid, TxLast;
  logic             TxReady = 1'b0;
  logic             FrameDropped;
  logic [PendW-1:0] FramesPending;
`ifdef RVVI_TXBUF_STATS_EN
  logic [31:0]      TxFrameCount, TxByteCount;
`endif

  rvvi_tx_frame_buffer #(
    .DEPTH_WORDS     (DEPTH_WORDS),
    .MAX_FRAMES      (MAX_FRAMES),
    .MIN_FRAME_BYTES (60)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .RvviAxiWdata  (RvviAxiWdata),
    .RvviAxiWstrb  (RvviAxiWstrb),
    .RvviAxiWlast  (RvviAxiWlast),
    .RvviAxiWvalid (RvviAxiWvalid),
    .RvviAxiWready (RvviAxiWready),
    .TxData        (TxData),
    .TxValid       (TxValid),
    .TxLast        (TxLast),
    .TxReady       (TxReady),
    .FrameDropped  (FrameDropped),
    .FramesPending (FramesPending)
`ifdef RVVI_TXBUF_STATS_EN
    ,
    .TxFrameCount  (TxFrameCount),
    .TxByteCount   (TxByteCount)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // 0: TxReady low, 1: TxReady high, 2: TxReady toggles every cycle
  int readyMode = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (readyMode)
      0:       TxReady = 1'b0;
      1:       TxReady = 1'b1;
      default: TxReady = ~TxReady;
    endcase
  end

  // Output monitor, sampled on the falling edge
  logic [7:0] rxBytes[$];
  bit         rxLast[$];
  int         gaps[$];
  int         stallErr, midDrop, gapCnt;
  bit         inFrame, afterLast, havePrev, prevValid, prevReady, prevLast;
  logic [7:0] prevData;

  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      inFrame   = 0;
      afterLast = 0;
      havePrev  = 0;
    end else begin
      if (havePrev && prevValid && !prevReady)
        if (TxValid !== prevValid || TxData !== prevData || TxLast !== prevLast) stallErr++;
      if (inFrame && !TxValid) midDrop++;
      if (!TxValid && afterLast) gapCnt++;
      if (TxValid && afterLast) begin
        gaps.push_back(gapCnt);
        afterLast = 0;
      end
      if (TxValid) inFrame = 1;
      if (TxValid && TxReady) begin
        rxBytes.push_back(TxData);
        rxLast.push_back(TxLast);
        if (TxLast) begin
          inFrame   = 0;
          afterLast = 1;
          gapCnt    = 0;
        end
      end
      prevValid = TxValid;
      prevReady = TxReady;
      prevData  = TxData;
      prevLast  = TxLast;
      havePrev  = 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_mon();
    rxBytes.delete();
    rxLast.delete();
    gaps.delete();
    stallErr  = 0;
    midDrop   = 0;
    gapCnt    = 0;
    inFrame   = 0;
    afterLast = 0;
  endtask

  // Writes one frame; word w carries bytes startByte+4w .. startByte+4w+3, LSB first.
  task automatic write_frame(input int nWords, input int startByte, output bit ok);
    bit got;
    ok = 1;
    @(posedge clk);
    #1;
    for (int w = 0; w < nWords; w++) begin
      for (int b = 0; b < 4; b++) RvviAxiWdata[8*b +: 8] = 8'(startByte + 4 * w + b);
      RvviAxiWlast  = (w == nWords - 1);
      RvviAxiWvalid = 1'b1;
      got = 0;
      for (int c = 0; c < 300 && !got; c++) begin
        @(negedge clk);
        got = RvviAxiWready;
        @(posedge clk);
        #1;
      end
      if (!got) ok = 0;
    end
    RvviAxiWvalid = 1'b0;
    RvviAxiWlast  = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input int maxCyc);
    for (int c = 0; c < maxCyc && rxBytes.size() < n; c++) @(negedge clk);
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #12;
    tests++; if (RvviAxiWready !== 1'b0) begin fails++; $display("FAIL reset_wready: got %b want 0", RvviAxiWready); end
    tests++; if (TxValid !== 1'b0) begin fails++; $display("FAIL reset_txvalid: got %b want 0", TxValid); end
    tests++; if (TxLast !== 1'b0) begin fails++; $display("FAIL reset_txlast: got %b want 0", TxLast); end
    tests++; if (TxData !== 8'h00) begin fails++; $display("FAIL reset_txdata: got %h want 00", TxData); end
    tests++; if (FrameDropped !== 1'b0) begin fails++; $display("FAIL reset_dropped: got %b want 0", FrameDropped); end
    tests++; if (FramesPending !== '0) begin fails++; $display("FAIL reset_pending: got %0d want 0", FramesPending); end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    tests++; if (RvviAxiWready !== 1'b0) begin fails++; $display("FAIL wready_before_edge: got %b want 0", RvviAxiWready); end
    @(posedge clk);
    #1;
    tests++; if (RvviAxiWready !== 1'b1) begin fails++; $display("FAIL wready_after_edge: got %b want 1", RvviAxiWready); end
  endtask

  task automatic test_full_frame();
    bit ok;
    clear_mon();
    readyMode = 1;
    write_frame(16, 0, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL full_write: got %b want 1", ok); end
    wait_bytes(64, 200);
    tests++; if (rxBytes.size() != 64) begin fails++; $display("FAIL full_count: got %0d want 64", rxBytes.size()); end
    for (int i = 0; i < 64 && i < rxBytes.size(); i++) begin
      tests++; if (rxBytes[i] !== 8'(i)) begin fails++; $display("FAIL full_byte[%0d]: got %h want %h", i, rxBytes[i], 8'(i)); end
      tests++; if (rxLast[i] !== (i == 63)) begin fails++; $display("FAIL full_last[%0d]: got %b want %b", i, rxLast[i], i == 63); end
    end
    tests++; if (midDrop != 0) begin fails++; $display("FAIL full_valid_gap: got %0d want 0", midDrop); end
  endtask

  task automatic test_short_frame();
    bit ok;
    logic [7:0] exp;
    clear_mon();
    readyMode = 1;
    write_frame(5, 'h40, ok);
    tests++; if (FramesPending !== PendW'(1)) begin fails++; $display("FAIL short_pending1: got %0d want 1", FramesPending); end
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL short_write: got %b want 1", ok); end
    wait_bytes(60, 200);
    tests++; if (rxBytes.size() != 60) begin fails++; $display("FAIL short_count: got %0d want 60", rxBytes.size()); end
    for (int i = 0; i < 60 && i < rxBytes.size(); i++) begin
      exp = (i < 20) ? 8'(8'h40 + i) : 8'h00;
      tests++; if (rxBytes[i] !== exp) begin fails++; $display("FAIL short_byte[%0d]: got %h want %h", i, rxBytes[i], exp); end
      tests++; if (rxLast[i] !== (i == 59)) begin fails++; $display("FAIL short_last[%0d]: got %b want %b", i, rxLast[i], i == 59); end
    end
    tests++; if (FramesPending !== '0) begin fails++; $display("FAIL short_pending0: got %0d want 0", FramesPending); end
  endtask

  task automatic test_back_to_back();
    bit okA, okB;
    clear_mon();
    readyMode = 0;
    write_frame(16, 'h80, okA);
    write_frame(16, 'hC0, okB);
    tests++; if ((okA & okB) !== 1'b1) begin fails++; $display("FAIL b2b_write: got %b want 1", okA & okB); end
    tests++; if (FramesPending !== PendW'(1)) begin fails++; $display("FAIL b2b_pending: got %0d want 1", FramesPending); end
    readyMode = 2;
    wait_bytes(128, 600);
    tests++; if (rxBytes.size() != 128) begin fails++; $display("FAIL b2b_count: got %0d want 128", rxBytes.size()); end
    for (int i = 0; i < 128 && i < rxBytes.size(); i++) begin
      tests++; if (rxBytes[i] !== 8'(8'h80 + i)) begin fails++; $display("FAIL b2b_byte[%0d]: got %h want %h", i, rxBytes[i], 8'(8'h80 + i)); end
      tests++; if (rxLast[i] !== (i == 63 || i == 127)) begin fails++; $display("FAIL b2b_last[%0d]: got %b", i, rxLast[i]); end
    end
    tests++; if (stallErr != 0) begin fails++; $display("FAIL b2b_stall_hold: got %0d changes want 0", stallErr); end
    tests++; if (midDrop != 0) begin fails++; $display("FAIL b2b_valid_gap: got %0d want 0", midDrop); end
    tests++; if (gaps.size() != 1) begin fails++; $display("FAIL b2b_gap_count: got %0d want 1", gaps.size()); end
    else begin
      tests++; if (gaps[0] != 1) begin fails++; $display("FAIL b2b_idle_cycles: got %0d want 1", gaps[0]); end
    end
  endtask

  task automatic test_drop();
    bit ok;
    clear_mon();
    readyMode = 0;
    tests++; if (FrameDropped !== 1'b0) begin fails++; $display("FAIL drop_pre: got %b want 0", FrameDropped); end
    write_frame(36, 0, ok);
    tests++; if (ok !== 1'b1) begin fails++; $display("FAIL drop_write: got %b want 1", ok); end
    tests++; if (FrameDropped !== 1'b1) begin fails++; $display("FAIL drop_flag: got %b want 1", FrameDropped); end
    tests++; if (FramesPending !== '0) begin fails++; $display("FAIL drop_pending: got %0d want 0", FramesPending); end
    tests++; if (RvviAxiWready !== 1'b1) begin fails++; $display("FAIL drop_wready: got %b want 1", RvviAxiWready); end
    readyMode = 1;
    write_frame(16, 'h10, ok);
    wait_bytes(64, 200);
    tests++; if (rxBytes.size() != 64) begin fails++; $display("FAIL drop_next_count: got %0d want 64", rxBytes.size()); end
    for (int i = 0; i < 64 && i < rxBytes.size(); i++) begin
      tests++; if (rxBytes[i] !== 8'(8'h10 + i)) begin fails++; $display("FAIL drop_next_byte[%0d]: got %h want %h", i, rxBytes[i], 8'(8'h10 + i)); end
    end
    tests++; if (rxLast.size() == 64 && rxLast[63] !== 1'b1) begin fails++; $display("FAIL drop_next_last: got %b want 1", rxLast[63]); end
  endtask

  task automatic test_lenq_full();
    bit ok, allOk, rose;
    int cnt;
    clear_mon();
    readyMode = 0;
    allOk = 1;
    for (int k = 0; k < 9; k++) begin
      write_frame(1, 'hD0 + 4 * k, ok);
      allOk &= ok;
    end
    tests++; if (allOk !== 1'b1) begin fails++; $display("FAIL lenq_write: got %b want 1", allOk); end
    tests++; if (FramesPending !== PendW'(8)) begin fails++; $display("FAIL lenq_pending8: got %0d want 8", FramesPending); end
    tests++; if (RvviAxiWready !== 1'b0) begin fails++; $display("FAIL lenq_backpressure: got %b want 0", RvviAxiWready); end
    readyMode = 1;
    for (int c = 0; c < 200 && rxBytes.size() < 60; c++) @(negedge clk);
    cnt  = 0;
    rose = 0;
    for (int c = 0; c < 6 && !rose; c++) begin
      @(posedge clk);
      #1;
      cnt++;
      rose = RvviAxiWready;
    end
    tests++; if (!rose || cnt > 2) begin fails++; $display("FAIL lenq_wready_resume: got %0d cycles want <=2", cnt); end
    wait_bytes(540, 1200);
    tests++; if (rxBytes.size() != 540) begin fails++; $display("FAIL lenq_count: got %0d want 540", rxBytes.size()); end
    for (int k = 0; k < 9 && rxBytes.size() == 540; k++) begin
      tests++; if (rxBytes[60*k] !== 8'(8'hD0 + 4 * k)) begin fails++; $display("FAIL lenq_first[%0d]: got %h want %h", k, rxBytes[60*k], 8'(8'hD0 + 4 * k)); end
      tests++; if (rxBytes[60*k+4] !== 8'h00) begin fails++; $display("FAIL lenq_pad[%0d]: got %h want 00", k, rxBytes[60*k+4]); end
      tests++; if (rxLast[60*k+59] !== 1'b1) begin fails++; $display("FAIL lenq_last[%0d]: got %b want 1", k, rxLast[60*k+59]); end
    end
    tests++; if (FramesPending !== '0) begin fails++; $display("FAIL lenq_pending0: got %0d want 0", FramesPending); end
  endtask

  task automatic test_reset_mid_send();
    bit okA, okB, ok;
    clear_mon();
    readyMode = 0;
    write_frame(16, 'h60, okA);
    write_frame(16, 'hA0, okB);
    tests++; if (FramesPending !== PendW'(1)) begin fails++; $display("FAIL rst_pre_pending: got %0d want 1", FramesPending); end
    tests++; if (TxValid !== 1'b1) begin fails++; $display("FAIL rst_pre_valid: got %b want 1", TxValid); end
    #2;
    resetn = 1'b0;
    #1;
    tests++; if (TxValid !== 1'b0) begin fails++; $display("FAIL rst_async_valid: got %b want 0", TxValid); end
    tests++; if (FramesPending !== '0) begin fails++; $display("FAIL rst_async_pending: got %0d want 0", FramesPending); end
    tests++; if (RvviAxiWready !== 1'b0) begin fails++; $display("FAIL rst_async_wready: got %b want 0", RvviAxiWready); end
    tests++; if (FrameDropped !== 1'b0) begin fails++; $display("FAIL rst_async_dropped: got %b want 0", FrameDropped); end
    @(negedge clk);
    resetn = 1'b1;
    clear_mon();
    readyMode = 1;
    write_frame(16, 'h20, ok);
    wait_bytes(64, 200);
    repeat (10) @(negedge clk);
    tests++; if (rxBytes.size() != 64) begin fails++; $display("FAIL rst_next_count: got %0d want 64", rxBytes.size()); end
    for (int i = 0; i < 64 && i < rxBytes.size(); i++) begin
      tests++; if (rxBytes[i] !== 8'(8'h20 + i)) begin fails++; $display("FAIL rst_next_byte[%0d]: got %h want %h", i, rxBytes[i], 8'(8'h20 + i)); end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_back_to_back();
    test_drop();
    test_lenq_full();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
